i2c_pad_conditioner: RTL and testbench

- Sits between the FPGA I2C pins (open-drain, to the HDMI transmitter config bus) and the Nios II I2C core's serial interface (sda_in/scl_in/sda_oe/scl_oe).
- Synchronizes and glitch-filters the pad inputs before they reach the core, and passes the core's open-drain enables to the pads.
- Monitors the bus for START/STOP, byte/ACK activity and stuck lines.
- Runs a hardware bus-recovery sequence (SCL pulsing plus STOP) on request.

---
 rtl/i2c_pad_conditioner.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_pad_conditioner.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_pad_conditioner.sv
// I2C pad conditioner: synchronizes and glitch-filters the open-drain pads for the I2C core,
// monitors START/STOP/byte/stuck activity and runs an SCL-pulsing bus recovery on request.
module i2c_pad_conditioner #(
  parameter int FILTER_LEN   = 4,
  parameter int STUCK_CYCLES = 1000000,
  parameter int HALF_PERIOD  = 250
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       pad_sda_in,
  input  logic       pad_scl_in,
  output logic       pad_sda_oe,
  output logic       pad_scl_oe,
  input  logic       core_sda_oe,
  input  logic       core_scl_oe,
  output logic       core_sda_in,
  output logic       core_scl_in,
  input  logic       recover_req,
  output logic       recover_active,
  output logic       recover_done,
  output logic       recover_fail,
  output logic       bus_busy,
  output logic       start_det,
  output logic       stop_det,
  output logic       nack_det,
  output logic [7:0] byte_count,
  output logic       stuck_err
);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam int HW = $clog2(HALF_PERIOD) + 1;

  typedef enum logic [2:0] {
    IDLE, PULSE_LOW, PULSE_HIGH, STOP_LOW, STOP_SCL_REL, STOP_SDA_REL, DONE
  } state_t;

  // Bit 0 carries SCL, bit 1 carries SDA through the sync/filter pipeline.
  logic [1:0]    raw, sync_p0, sync_p1, filt;
  logic [FW-1:0] fcnt [2];

  assign raw = {pad_sda_in, pad_scl_in};

  // Stage boundary: two synchronizer flops, then per-line stability filter
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
      filt    <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= sync_p1[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  logic          scl_f, sda_f, scl_q, sda_q;
  logic          start_c, stop_c, scl_rise;
  state_t        state, state_nx;
  logic [HW-1:0] hp_cnt;
  logic [3:0]    pulse_cnt, bit_cnt;
  logic [SW-1:0] stuck_cnt;
  logic          rec_scl_oe, rec_sda_oe, hp_adv, hp_last, accept, pulse_end;

  assign scl_f          = filt[0];
  assign sda_f          = filt[1];
  assign hp_last        = (hp_cnt == HW'(HALF_PERIOD - 1));
  assign accept         = (state == IDLE) && recover_req;
  assign pulse_end      = (state == PULSE_HIGH) && scl_f && hp_last;
  assign recover_active = (state != IDLE) && (state != DONE);
  assign recover_done   = (state == DONE);
  assign pad_scl_oe     = recover_active ? rec_scl_oe : core_scl_oe;
  assign pad_sda_oe     = recover_active ? rec_sda_oe : core_sda_oe;
  assign core_scl_in    = recover_active | scl_f;
  assign core_sda_in    = recover_active | sda_f;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nx;
  end

  // High phases only advance while SCL reads high, so a stretching slave lengthens them.
  always_comb begin
    state_nx   = state;
    rec_scl_oe = 1'b0;
    rec_sda_oe = 1'b0;
    hp_adv     = 1'b0;
    case (state)
      IDLE:         if (recover_req) state_nx = PULSE_LOW;
      PULSE_LOW: begin
        rec_scl_oe = 1'b1;
        hp_adv     = 1'b1;
        if (hp_last) state_nx = PULSE_HIGH;
      end
      PULSE_HIGH: begin
        hp_adv = scl_f;
        if (pulse_end) state_nx = (sda_f || pulse_cnt == 4'd8) ? STOP_LOW : PULSE_LOW;
      end
      STOP_LOW: begin
        rec_scl_oe = 1'b1;
        rec_sda_oe = 1'b1;
        hp_adv     = 1'b1;
        if (hp_last) state_nx = STOP_SCL_REL;
      end
      STOP_SCL_REL: begin
        rec_sda_oe = 1'b1;
        hp_adv     = scl_f;
        if (scl_f && hp_last) state_nx = STOP_SDA_REL;
      end
      STOP_SDA_REL: begin
        hp_adv = 1'b1;
        if (hp_last) state_nx = DONE;
      end
      DONE:         state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hp_cnt       <= '0;
      pulse_cnt    <= '0;
      recover_fail <= 1'b0;
    end else begin
      if (state_nx != state) hp_cnt <= '0;
      else if (hp_adv)       hp_cnt <= hp_cnt + HW'(1);
      if (accept) begin
        pulse_cnt    <= '0;
        recover_fail <= 1'b0;
      end else if (pulse_end) begin
        pulse_cnt <= pulse_cnt + 4'd1;
        if (!sda_f && pulse_cnt == 4'd8) recover_fail <= 1'b1;
      end
    end
  end

  // Simultaneous SCL and SDA edges fail the scl_q & scl_f term, so they never qualify.
  assign start_c  = scl_q & scl_f & sda_q & ~sda_f;
  assign stop_c   = scl_q & scl_f & ~sda_q & sda_f;
  assign scl_rise = ~scl_q & scl_f;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      nack_det   <= 1'b0;
      bus_busy   <= 1'b0;
      bit_cnt    <= '0;
      byte_count <= '0;
    end else begin
      scl_q     <= scl_f;
      sda_q     <= sda_f;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      nack_det  <= 1'b0;
      if (state == DONE) begin
        bus_busy <= 1'b0;
        bit_cnt  <= '0;
      end else if (!recover_active) begin
        if (start_c) begin
          start_det  <= 1'b1;
          bus_busy   <= 1'b1;
          bit_cnt    <= '0;
          byte_count <= '0;
        end else if (stop_c) begin
          stop_det <= 1'b1;
          bus_busy <= 1'b0;
          bit_cnt  <= '0;
        end else if (bus_busy && scl_rise) begin
          if (bit_cnt == 4'd8) begin
            bit_cnt  <= '0;
            nack_det <= sda_f;
            if (byte_count != 8'hFF) byte_count <= byte_count + 8'd1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      stuck_cnt <= '0;
      stuck_err <= 1'b0;
    end else if (recover_active || accept) begin
      stuck_cnt <= '0;
      if (accept) stuck_err <= 1'b0;
    end else if (!scl_f || (!sda_f && !bus_busy)) begin
      if (stuck_cnt != SW'(STUCK_CYCLES)) stuck_cnt <= stuck_cnt + SW'(1);
      if (stuck_cnt >= SW'(STUCK_CYCLES - 1)) stuck_err <= 1'b1;
    end else begin
      stuck_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_i2c_pad_conditioner.sv
// Bench for i2c_pad_conditioner: models the open-drain bus, drives I2C traffic from a
// vector table and checks filtering, monitoring, stuck detection and bus recovery.
module tb_i2c_pad_conditioner;
  localparam int FL = 4;
  localparam int SC = 1000;
  localparam int HP = 20;
  localparam int H  = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       pad_sda_in, pad_scl_in, pad_sda_oe, pad_scl_oe;
  logic       core_sda_oe, core_scl_oe, core_sda_in, core_scl_in;
  logic       recover_req, recover_active, recover_done, recover_fail;
  logic       bus_busy, start_det, stop_det, nack_det, stuck_err;
  logic [7:0] byte_count;
  logic       tb_scl_low, tb_sda_low;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  int n_stop  = 0;
  int n_nack  = 0;

  assign pad_scl_in = !(pad_scl_oe || tb_scl_low);
  assign pad_sda_in = !(pad_sda_oe || tb_sda_low);

  i2c_pad_conditioner #(.FILTER_LEN(FL), .STUCK_CYCLES(SC), .HALF_PERIOD(HP)) dut (
    .clk_clk(clk), .reset_reset(rst),
    .pad_sda_in(pad_sda_in), .pad_scl_in(pad_scl_in),
    .pad_sda_oe(pad_sda_oe), .pad_scl_oe(pad_scl_oe),
    .core_sda_oe(core_sda_oe), .core_scl_oe(core_scl_oe),
    .core_sda_in(core_sda_in), .core_scl_in(core_scl_in),
    .recover_req(recover_req), .recover_active(recover_active),
    .recover_done(recover_done), .recover_fail(recover_fail),
    .bus_busy(bus_busy), .start_det(start_det), .stop_det(stop_det),
    .nack_det(nack_det), .byte_count(byte_count), .stuck_err(stuck_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_det) n_start <= n_start + 1;
    if (stop_det)  n_stop  <= n_stop + 1;
    if (nack_det)  n_nack  <= n_nack + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef enum {OP_START, OP_BYTE, OP_STOP} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] data;
    bit         ack;
    bit         exp_busy;
    int         exp_bytes;
    int         exp_starts;
    int         exp_stops;
    int         exp_nacks;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv_scl(input bit v);
    tb_scl_low = !v;
    cyc(H);
  endtask

  task automatic drv_sda(input bit v);
    tb_sda_low = !v;
    cyc(H);
  endtask

  task automatic send_bit(input bit v);
    drv_sda(v);
    drv_scl(1'b1);
    drv_scl(1'b0);
  endtask

  task automatic do_recovery(input int release_at, input int stretch_at, input bit toggle,
                             output int pulses, output int lo1, output int hi1, output int hi_s,
                             output bit stop_ok, output int viol, output int done_cnt);
    int hi_len [10];
    bit prev_oe, saw_low, saw_rel;
    int str_left, n;
    pulses = 0; lo1 = 0; stop_ok = 1'b0; viol = 0; done_cnt = 0;
    saw_low = 1'b0; saw_rel = 1'b0; str_left = 0; n = 0; prev_oe = 1'b0;
    for (int k = 0; k < 10; k++) hi_len[k] = 0;
    recover_req = 1'b1;
    @(posedge clk); #1;
    recover_req = 1'b0;
    while (done_cnt == 0 && n < 6000) begin
      if (str_left > 0) begin
        str_left--;
        if (str_left == 0) tb_scl_low = 1'b0;
      end
      if (pad_scl_oe && pad_sda_oe) saw_low = 1'b1;
      if (saw_low && !pad_scl_oe && pad_sda_oe) saw_rel = 1'b1;
      if (saw_rel && !pad_scl_oe && !pad_sda_oe) stop_ok = 1'b1;
      if (prev_oe && !pad_scl_oe && !pad_sda_oe && !saw_low) begin
        pulses++;
        if (pulses == release_at) tb_sda_low = 1'b0;
        if (pulses == stretch_at) begin
          tb_scl_low = 1'b1;
          str_left   = 100;
        end
      end
      if (pulses == 0 && pad_scl_oe) lo1++;
      if (pulses > 0 && pulses < 10 && !pad_scl_oe && !saw_low) hi_len[pulses]++;
      if (recover_active && (!core_scl_in || !core_sda_in)) viol++;
      if (recover_active && !saw_low && pad_sda_oe) viol++;
      if (recover_done) done_cnt++;
      prev_oe = pad_scl_oe;
      if (toggle && !saw_low) begin
        core_sda_oe = n[0];
        core_scl_oe = ~n[0];
      end else begin
        core_sda_oe = 1'b0;
        core_scl_oe = 1'b0;
      end
      n++;
      @(posedge clk); #1;
    end
    hi1  = hi_len[1];
    hi_s = (stretch_at > 0 && stretch_at < 10) ? hi_len[stretch_at] : 0;
  endtask

  initial begin
    int base, bad, pulses, lo1, hi1, hi_s, viol, done_cnt, b_start, b_stop, b_nack;
    bit stop_ok;

    tbl[0] = '{OP_START, 8'h00, 1'b0, 1'b1, 0, 1, 0, 0};
    tbl[1] = '{OP_BYTE,  8'hA5, 1'b0, 1'b1, 1, 1, 0, 0};
    tbl[2] = '{OP_BYTE,  8'h3C, 1'b0, 1'b1, 2, 1, 0, 0};
    tbl[3] = '{OP_BYTE,  8'hFF, 1'b1, 1'b1, 3, 1, 0, 1};
    tbl[4] = '{OP_STOP,  8'h00, 1'b0, 1'b0, 3, 1, 1, 1};
    tbl[5] = '{OP_START, 8'h00, 1'b0, 1'b1, 0, 2, 1, 1};
    tbl[6] = '{OP_BYTE,  8'h00, 1'b0, 1'b1, 1, 2, 1, 1};
    tbl[7] = '{OP_START, 8'h00, 1'b0, 1'b1, 0, 3, 1, 1};
    tbl[8] = '{OP_BYTE,  8'h81, 1'b1, 1'b1, 1, 3, 1, 2};
    tbl[9] = '{OP_STOP,  8'h00, 1'b0, 1'b0, 1, 3, 2, 2};

    rst = 1'b1; tb_scl_low = 1'b0; tb_sda_low = 1'b0;
    core_sda_oe = 1'b0; core_scl_oe = 1'b0; recover_req = 1'b0;
    cyc(3);
    chk("reset core_in", {core_scl_in, core_sda_in}, 2'b11);
    chk("reset pad_oe", {pad_scl_oe, pad_sda_oe}, 2'b00);
    chk("reset flags", {bus_busy, stuck_err, recover_active, recover_fail, recover_done}, 0);
    chk("reset pulses", {start_det, stop_det, nack_det}, 0);
    chk("reset byte_count", byte_count, 0);
    rst = 1'b0;
    cyc(5);

    core_scl_oe = 1'b1; #1;
    chk("pass scl_oe", pad_scl_oe, 1);
    core_scl_oe = 1'b0; core_sda_oe = 1'b1; #1;
    chk("pass sda_oe", {pad_scl_oe, pad_sda_oe}, 2'b01);
    core_sda_oe = 1'b0;
    cyc(2);

    bad = 0;
    tb_scl_low = 1'b1;
    cyc(3);
    tb_scl_low = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (!core_scl_in) bad++;
      cyc(1);
    end
    chk("scl glitch 3 rejected", bad, 0);

    tb_scl_low = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      if (k == 5) chk("scl fall latency-1", core_scl_in, 1);
      if (k == 6) chk("scl fall latency", core_scl_in, 0);
    end
    cyc(4);
    tb_scl_low = 1'b0;
    cyc(20);

    base = n_start; bad = 0;
    tb_sda_low = 1'b1;
    cyc(3);
    tb_sda_low = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (!core_sda_in) bad++;
      cyc(1);
    end
    chk("sda glitch 3 rejected", bad, 0);
    chk("sda glitch no start", n_start - base, 0);
    chk("sda glitch not busy", bus_busy, 0);

    b_start = n_start; b_stop = n_stop; b_nack = n_nack;
    for (int i = 0; i < 10; i++) begin
      case (tbl[i].op)
        OP_START: begin
          drv_sda(1'b1); drv_scl(1'b1); drv_sda(1'b0); drv_scl(1'b0);
        end
        OP_BYTE: begin
          for (int b = 7; b >= 0; b--) send_bit(tbl[i].data[b]);
          send_bit(tbl[i].ack);
        end
        default: begin
          drv_sda(1'b0); drv_scl(1'b1); drv_sda(1'b1);
        end
      endcase
      chk($sformatf("row%0d bus_busy", i), bus_busy, tbl[i].exp_busy);
      chk($sformatf("row%0d byte_count", i), byte_count, tbl[i].exp_bytes);
      chk($sformatf("row%0d starts", i), n_start - b_start, tbl[i].exp_starts);
      chk($sformatf("row%0d stops", i), n_stop - b_stop, tbl[i].exp_stops);
      chk($sformatf("row%0d nacks", i), n_nack - b_nack, tbl[i].exp_nacks);
    end

    // Both lines drop together (no START), SCL then released while SDA stays stuck low.
    tb_scl_low = 1'b1; tb_sda_low = 1'b1;
    bad = 1;
    for (int k = 0; k < 20 && bad != 0; k++) begin
      cyc(1);
      if (!core_sda_in) bad = 0;
    end
    chk("stuck sda filtered low", bad, 0);
    cyc(20);
    tb_scl_low = 1'b0;
    cyc(979);
    chk("stuck_err at 999", stuck_err, 0);
    cyc(1);
    chk("stuck_err at 1000", stuck_err, 1);
    chk("stuck no busy", bus_busy, 0);

    do_recovery(3, 2, 1'b0, pulses, lo1, hi1, hi_s, stop_ok, viol, done_cnt);
    chk("recA done pulse", done_cnt, 1);
    chk("recA pulses", pulses, 3);
    chk("recA low phase", lo1, HP);
    chk("recA high phase", hi1, HP + FL + 2);
    chk("recA stretched high", hi_s, HP + FL + 2 + 100);
    chk("recA stop issued", stop_ok, 1);
    chk("recA core_in forced", viol, 0);
    chk("recA done one cycle", {recover_done, recover_active}, 2'b00);
    chk("recA flags", {stuck_err, recover_fail, bus_busy}, 3'b000);

    tb_sda_low = 1'b1;
    cyc(H);
    do_recovery(0, 0, 1'b1, pulses, lo1, hi1, hi_s, stop_ok, viol, done_cnt);
    chk("recB done pulse", done_cnt, 1);
    chk("recB pulses", pulses, 9);
    chk("recB low phase", lo1, HP);
    chk("recB high phase", hi1, HP + FL + 2);
    chk("recB stop issued", stop_ok, 1);
    chk("recB core isolation", viol, 0);
    chk("recB fail", recover_fail, 1);
    chk("recB bus_busy", bus_busy, 0);
    cyc(5);
    chk("recB fail sticky", recover_fail, 1);

    recover_req = 1'b1;
    cyc(1);
    recover_req = 1'b0;
    cyc(10);
    chk("recC active", recover_active, 1);
    chk("recC fail cleared", recover_fail, 0);
    chk("recC scl driven", pad_scl_oe, 1);
    rst = 1'b1;
    cyc(1);
    chk("reset mid-rec pads", {pad_scl_oe, pad_sda_oe}, 2'b00);
    chk("reset mid-rec flags", {recover_active, recover_fail, stuck_err, bus_busy}, 0);
    rst = 1'b0;
    tb_sda_low = 1'b0;
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
